// File: rtl/mem_arb.sv
// mem_arb: arbitrates NUM_MST masters onto a single slave port, with one
// transaction in flight at a time, an optional response timeout, and a
// response routed back to the master that won the grant.
module mem_arb #(
   parameter int NUM_MST     = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ARB_MODE    = 1,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                             i_sys_clk,
   input  logic                             i_sys_rst_n,
   input  logic [NUM_MST-1:0]               i_mst_req_valid,
   output logic [NUM_MST-1:0]               o_mst_req_ready,
   input  logic [NUM_MST-1:0]               i_mst_req_wr_en,
   input  logic [NUM_MST*ADDR_WIDTH-1:0]    i_mst_req_addr,
   input  logic [NUM_MST*DATA_WIDTH-1:0]    i_mst_req_wr_data,
   input  logic [NUM_MST*DATA_WIDTH/8-1:0]  i_mst_req_wr_mask,
   output logic [NUM_MST-1:0]               o_mst_rsp_valid,
   output logic [DATA_WIDTH-1:0]            o_mst_rsp_rd_data,
   output logic                             o_mst_rsp_err,
   output logic                             o_slv_req_valid,
   input  logic                             i_slv_req_ready,
   output logic                             o_slv_req_wr_en,
   output logic [ADDR_WIDTH-1:0]            o_slv_req_addr,
   output logic [DATA_WIDTH-1:0]            o_slv_req_wr_data,
   output logic [DATA_WIDTH/8-1:0]          o_slv_req_wr_mask,
   input  logic                             i_slv_rsp_valid,
   input  logic [DATA_WIDTH-1:0]            i_slv_rsp_rd_data
);

   localparam int MASK_W  = DATA_WIDTH / 8;
   localparam int IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_last_grant;
   logic [IDX_W-1:0]    r_winner;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_slv_valid;
   logic                r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [MASK_W-1:0]   r_wr_mask;
   logic [NUM_MST-1:0]  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rd_data;
   logic                r_rsp_err;

   logic                w_found;
   logic [IDX_W-1:0]    w_win_idx;
   logic [IDX_W-1:0]    w_cand;
   int                  w_idx;
   logic                w_expired;

   // Pick the winner: lowest index in fixed mode, or first valid after the
   // previous grant (wrapping) in round-robin mode.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = '0;
      w_idx     = 0;
      w_cand    = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (ARB_MODE == 0) begin
            w_idx = i;
         end else begin
            w_idx = int'(r_last_grant) + 1 + i;
            if (w_idx >= NUM_MST) begin
               w_idx = w_idx - NUM_MST;
            end
         end
         w_cand = IDX_W'(w_idx);
         if (!w_found && i_mst_req_valid[w_cand]) begin
            w_found   = 1'b1;
            w_win_idx = w_cand;
         end
      end
   end

   // Accept is combinational so the master sees it in the grant cycle; it is
   // also masked by reset so every output reads zero while reset is held.
   assign o_mst_req_ready = (i_sys_rst_n && (r_state == IDLE) && w_found)
                            ? (NUM_MST'(1) << w_win_idx) : '0;

   assign w_expired = (TIMEOUT_CYC > 0) && (r_cnt == CNT_W'(TO_LAST));

   assign o_slv_req_valid   = r_slv_valid;
   assign o_slv_req_wr_en   = r_wr_en;
   assign o_slv_req_addr    = r_addr;
   assign o_slv_req_wr_data = r_wr_data;
   assign o_slv_req_wr_mask = r_wr_mask;
   assign o_mst_rsp_valid   = r_rsp_valid;
   assign o_mst_rsp_rd_data = r_rsp_rd_data;
   assign o_mst_rsp_err     = r_rsp_err;

   // Transaction FSM: capture on grant, hold request until slave accepts,
   // then wait for a response or a timeout and return a one-cycle pulse.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_state       <= IDLE;
         r_last_grant  <= IDX_W'(NUM_MST - 1);
         r_winner      <= '0;
         r_cnt         <= '0;
         r_slv_valid   <= 1'b0;
         r_wr_en       <= 1'b0;
         r_addr        <= '0;
         r_wr_data     <= '0;
         r_wr_mask     <= '0;
         r_rsp_valid   <= '0;
         r_rsp_rd_data <= '0;
         r_rsp_err     <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_winner     <= w_win_idx;
                  r_last_grant <= w_win_idx;
                  r_wr_en      <= i_mst_req_wr_en[w_win_idx];
                  r_addr       <= i_mst_req_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  r_wr_data    <= i_mst_req_wr_data[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
                  r_wr_mask    <= i_mst_req_wr_mask[w_win_idx*MASK_W +: MASK_W];
                  r_slv_valid  <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_slv_req_ready) begin
                  r_slv_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               // A real response takes precedence over an expiring timer.
               if (i_slv_rsp_valid) begin
                  r_rsp_valid   <= NUM_MST'(1) << r_winner;
                  r_rsp_rd_data <= i_slv_rsp_rd_data;
                  r_rsp_err     <= 1'b0;
                  r_state       <= IDLE;
               end else if (w_expired) begin
                  r_rsp_valid   <= NUM_MST'(1) << r_winner;
                  r_rsp_rd_data <= '0;
                  r_rsp_err     <= 1'b1;
                  r_state       <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_MST, 2: number of requesting masters.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; mask width is DATA_WIDTH/8.
- ARB_MODE, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
- TIMEOUT_CYC, 16: response timeout in cycles; 0 disables the timeout.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_sys_clk, in, 1: the single clock; all state on its rising edge.
- i_sys_rst_n, in, 1: reset, asynchronous, active-low.
- i_mst_req_valid, in, NUM_MST: per-master request valid.
- o_mst_req_ready, out, NUM_MST: one-hot accept pulse.
- i_mst_req_wr_en, in, NUM_MST: 1 = write, 0 = read.
- i_mst_req_addr, in, NUM_MST*ADDR_WIDTH: packed addresses; master k at slice k.
- i_mst_req_wr_data, in, NUM_MST*DATA_WIDTH: packed write data.
- i_mst_req_wr_mask, in, NUM_MST*DATA_WIDTH/8: packed byte masks.
- o_mst_rsp_valid, out, NUM_MST: one-hot response pulse.
- o_mst_rsp_rd_data, out, DATA_WIDTH: shared read data.
- o_mst_rsp_err, out, 1: timeout error flag for the current response.
- o_slv_req_valid, out, 1: slave request valid.
- i_slv_req_ready, in, 1: slave accepts the request.
- o_slv_req_wr_en, out, 1: slave write enable.
- o_slv_req_addr, out, ADDR_WIDTH: slave address.
- o_slv_req_wr_data, out, DATA_WIDTH: slave write data.
- o_slv_req_wr_mask, out, DATA_WIDTH/8: slave byte mask.
- i_slv_rsp_valid, in, 1: slave response valid (reads and writes).
- i_slv_rsp_rd_data, in, DATA_WIDTH: slave read data.

Function
REQ-003 FSM SHALL have states IDLE, ISSUE and WAIT_RSP; exactly one transaction is outstanding at a time.
REQ-004 In IDLE with any i_mst_req_valid set, the block SHALL:
- pick the winner per ARB_MODE;
- drive o_mst_req_ready[winner]=1 combinationally that cycle;
- register winner index, wr_en, addr, data and mask;
- go to ISSUE.
REQ-005 o_mst_req_ready SHALL be 0 in ISSUE and WAIT_RSP, and 0 in IDLE when no valid is set.
REQ-006 Round-robin SHALL search from index (last_grant+1) mod NUM_MST upward with wrap; last_grant updates only on a grant.
REQ-007 Fixed priority SHALL grant the lowest set index.
REQ-008 ISSUE SHALL:
- hold o_slv_req_valid=1 with stable registered payload until i_slv_req_ready=1;
- on that cycle go to WAIT_RSP.
REQ-009 o_slv_req_valid SHALL be 0 outside ISSUE.
REQ-010 On entry to WAIT_RSP the timeout counter SHALL clear; it increments each WAIT_RSP cycle without i_slv_rsp_valid.
REQ-011 i_slv_rsp_valid in WAIT_RSP SHALL produce, on the next cycle, for exactly one cycle:
- o_mst_rsp_valid[winner]=1;
- o_mst_rsp_rd_data = captured i_slv_rsp_rd_data;
- o_mst_rsp_err=0.
The FSM then returns to IDLE.
REQ-012 If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 with no response, the next cycle SHALL carry a one-cycle response to the winner with err=1 and rd_data=0; the FSM returns to IDLE.
REQ-013 If i_slv_rsp_valid coincides with the timeout-expiry cycle, the slave response SHALL win (err=0).
REQ-014 i_slv_rsp_valid in IDLE or ISSUE, including late responses after a timeout, SHALL be ignored.
REQ-015 o_mst_rsp_rd_data and o_mst_rsp_err SHALL hold their values between responses.
REQ-016 Minimum latency SHALL be 3 cycles from master accept (cycle 0) to o_mst_rsp_valid, given slave ready at cycle 1 and response at cycle 2.
REQ-017 A new grant SHALL be possible in the same cycle that o_mst_rsp_valid is asserted (the FSM is in IDLE).
REQ-018 The slave SHALL return a response for writes; the returned rd_data passes through unchanged.

Reset
REQ-019 Asserting i_sys_rst_n low SHALL asynchronously force IDLE at any state, including mid-transaction; the outstanding transaction is dropped with no response.
REQ-020 During reset:
- all outputs SHALL be 0;
- last_grant SHALL be NUM_MST-1, so master 0 has first priority;
- the timeout counter SHALL be 0.
REQ-021 After release the block SHALL accept a request on the first rising edge.

Verification
REQ-022 Single read: m0 reads 0x100; slave ready at once, rsp 0xDEADBEEF next cycle. Required: o_mst_rsp_valid=01 three cycles after accept, rd_data=0xDEADBEEF, err=0.
REQ-023 Round-robin: m0 and m1 valid continuously, ARB_MODE=1. Required: grants alternate m0, m1, m0, m1. With ARB_MODE=0: m0 always wins.
REQ-024 Backpressure: i_slv_req_ready low for 5 cycles. Required: o_slv_req_valid and payload stable for all 5 cycles; no master ready asserted.
REQ-025 Timeout: TIMEOUT_CYC=4, no slave rsp. Required: err=1 and rd_data=0 to the winner after 4 WAIT_RSP cycles; a late rsp is ignored. Rsp on the expiry cycle yields err=0.
REQ-026 Reset mid-WAIT_RSP. Required: all outputs 0 immediately; no response pulse. After release, m0 and m1 valid together: m0 granted first.
